sig_cdc_sender: RTL and testbench

- Source-side (transmit) end of a toggle-handshake multi-bit clock-domain crossing.
- Captures an N-bit word in the local clkin domain and holds it stable on bus_data. It then toggles bus_req and waits for the destination domain's bus_ack toggle.
- bus_ack is asynchronous and is brought in through a 3-stage synchronizer.
- The destination side samples bus_data through its own multi-flop synchronizer once it sees bus_req change. This block guarantees bus_data never changes while a transfer is outstanding.

---
 rtl/sig_cdc_pkg.sv | 16 +
 rtl/sig_syncro.sv | 30 +++
 rtl/sig_cdc_sender.sv | 87 ++++++++
 tb/tb_sig_cdc_sender.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/sig_cdc_pkg.sv
// sig_cdc_pkg: shared types and constants for the toggle-handshake CDC sender.
`default_nettype none

package sig_cdc_pkg;

  localparam int ACK_SYNC_STAGES = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETUP    = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sig_syncro.sv
// sig_syncro: N-bit multi-flop synchronizer with async active-low reset.
`default_nettype none

module sig_syncro
  import sig_cdc_pkg::*;
#(
  parameter int N      = 1,
  parameter int STAGES = ACK_SYNC_STAGES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] din,
  output logic [N-1:0] dout
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES*N-1:0] sync_ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else begin
      sync_ff <= {sync_ff[(STAGES-1)*N-1:0], din};
    end
  end

  assign dout = sync_ff[STAGES*N-1 -: N];

endmodule

`default_nettype wire

// File: rtl/sig_cdc_sender.sv
// sig_cdc_sender: source side of a toggle req/ack multi-bit CDC; holds bus_data
// stable from accept until the synchronized ack parity matches bus_req.
`default_nettype none

module sig_cdc_sender
  import sig_cdc_pkg::*;
#(
  parameter int N         = 24,
  parameter int SETUP_CYC = 1,
  parameter int DROP_W    = 8
) (
  input  logic              clkin,
  input  logic              reset_n,
  input  logic [N-1:0]      data_in,
  input  logic              data_valid,
  output logic              ready,
  output logic [N-1:0]      bus_data,
  output logic              bus_req,
  input  logic              bus_ack,
  output logic              busy,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam logic [3:0] SETUP_INIT = 4'(SETUP_CYC - 1);

  state_t     state;
  logic [3:0] setup_cnt;
  logic       ack_s;

  sig_syncro #(
    .N      (1),
    .STAGES (ACK_SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clkin),
    .rst_n (reset_n),
    .din   (bus_ack),
    .dout  (ack_s)
  );

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bus_data  <= '0;
      bus_req   <= 1'b0;
      setup_cnt <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (data_valid) begin
            bus_data  <= data_in;
            setup_cnt <= SETUP_INIT;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (setup_cnt == 4'd0) begin
            bus_req <= ~bus_req;
            state   <= WAIT_ACK;
          end else begin
            setup_cnt <= setup_cnt - 4'd1;
          end
        end
        // ack is only compared here, so an early ack toggle during SETUP is ignored
        WAIT_ACK: begin
          if (ack_s == bus_req) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      drop_cnt <= '0;
    end else if (data_valid && (state != IDLE) && (drop_cnt != {DROP_W{1'b1}})) begin
      drop_cnt <= drop_cnt + DROP_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sig_cdc_sender.sv
// tb_sig_cdc_sender: scoreboard bench; a latency-based protocol model predicts
// accepts, drops and req edges, and a negedge monitor checks the DUT against it.
`default_nettype none

module tb_sig_cdc_sender;

  localparam int N         = 24;
  localparam int SETUP_CYC = 1;
  localparam int DROP_W    = 2;
  localparam int ACK_DLY   = 2;
  localparam int LAT       = SETUP_CYC + ACK_DLY + 3 + 1;
  localparam int NEVER     = 32'h7fffffff;
  localparam int DROP_MAX  = (1 << DROP_W) - 1;

  typedef struct {
    logic [N-1:0] word;
    int           cyc;
    logic         req;
  } exp_t;

  logic              clkin;
  logic              reset_n;
  logic [N-1:0]      data_in;
  logic              data_valid;
  logic              ready;
  logic [N-1:0]      bus_data;
  logic              bus_req;
  logic              bus_ack;
  logic              busy;
  logic [DROP_W-1:0] drop_cnt;

  sig_cdc_sender #(
    .N         (N),
    .SETUP_CYC (SETUP_CYC),
    .DROP_W    (DROP_W)
  ) dut (
    .clkin      (clkin),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .ready      (ready),
    .bus_data   (bus_data),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  // Destination stand-in: echoes bus_req back on bus_ack two cycles later unless held.
  logic ack_d1;
  logic ack_hold;
  always @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      ack_d1  <= 1'b0;
      bus_ack <= 1'b0;
    end else if (!ack_hold) begin
      ack_d1  <= bus_req;
      bus_ack <= ack_d1;
    end
  end

  int           tests = 0;
  int           fails = 0;
  int           cyc = 0;
  int           ready_at = 0;
  int           drops = 0;
  logic         model_ready = 1'b1;
  logic [N-1:0] model_word = '0;
  logic         exp_req = 1'b0;
  exp_t         exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    model_ready = 1'b1;
    ready_at    = 0;
    drops       = 0;
    model_word  = '0;
    exp_req     = 1'b0;
    exp_q.delete();
  endtask

  // One clock: update the model at the rising edge, return at the falling edge.
  task automatic tick();
    @(posedge clkin);
    cyc++;
    if (reset_n) begin
      if (data_valid) begin
        if (model_ready) begin
          model_word = data_in;
          exp_req    = ~exp_req;
          exp_q.push_back('{word: data_in, cyc: cyc + SETUP_CYC, req: exp_req});
          ready_at   = ack_hold ? NEVER : cyc + LAT;
        end else if (drops < DROP_MAX) begin
          drops++;
        end
      end
      model_ready = (cyc >= ready_at);
    end
    @(negedge clkin);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!model_ready && n < 100) begin
      tick();
      n++;
    end
    if (!model_ready) begin
      tests++;
      fails++;
      $display("FAIL wait_ready: model still busy after %0d cycles", n);
    end
  endtask

  task automatic send(input logic [N-1:0] word);
    wait_ready();
    data_valid = 1'b1;
    data_in    = word;
    tick();
    data_valid = 1'b0;
  endtask

  // Monitor: lockstep status checks plus scoreboard pop on every bus_req edge.
  logic prev_req = 1'b0;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge clkin);
      if (!reset_n) begin
        check("rst_ready", ready, 1);
        check("rst_busy", busy, 0);
        check("rst_req", bus_req, 0);
        check("rst_data", bus_data, 0);
        check("rst_drop", drop_cnt, 0);
        prev_req = 1'b0;
      end else begin
        check("ready", ready, model_ready);
        check("busy", busy, !model_ready);
        check("drop_cnt", drop_cnt, drops);
        check("bus_data_hold", bus_data, model_word);
        if (bus_req != prev_req) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL req_edge: spurious bus_req edge to %0b at cycle %0d", bus_req, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            check("req_data", bus_data, mon_e.word);
            check("req_cycle", cyc, mon_e.cyc);
            check("req_value", bus_req, mon_e.req);
          end
        end
        prev_req = bus_req;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    ack_hold   = 1'b0;
    data_valid = 1'b0;
    data_in    = '0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      data_valid = 1'($urandom_range(0, 1));
      data_in    = N'($urandom);
      tick();
    end
    data_valid = 1'b0;
    #2 reset_n = 1'b1;
    repeat (4) begin
      data_in = N'($urandom);
      tick();
    end

    send(24'hA5C3F0);
    send(24'h000001);
    send(24'h000002);
    send(24'h000003);

    // Ack withheld: drops saturate, bus_data and bus_req stay frozen.
    wait_ready();
    ack_hold = 1'b1;
    send(24'h3C3C3C);
    data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data_in = N'($urandom);
      tick();
    end
    data_valid = 1'b0;
    repeat (1000) tick();
    check("stuck_req", bus_req, 1);
    check("stuck_busy", busy, 1);

    #2 reset_n = 1'b0;
    ack_hold = 1'b0;
    #1;
    check("async_rst_req", bus_req, 0);
    check("async_rst_ready", ready, 1);
    model_reset();
    tick();
    tick();
    #2 reset_n = 1'b1;

    send(24'h5A5A5A);
    for (int i = 0; i < 400; i++) begin
      data_valid = ($urandom_range(0, 2) == 0);
      data_in    = N'($urandom);
      tick();
    end
    data_valid = 1'b0;
    wait_ready();
    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
